// File: rtl/router_pkg.sv
// Shared constants and types for the output-port arbiter.
package router_pkg;
  localparam int NPORTS = 16;
  localparam int PORT_W = 4;

  typedef logic [PORT_W-1:0] port_id_t;
  typedef enum logic {IDLE, OWNED} arb_state_t;
endpackage

// File: rtl/router_rr_pick.sv
// Combinational 16-way round-robin picker: first requester strictly after ptr, wrapping.
module router_rr_pick
  import router_pkg::*;
(
  input  logic [NPORTS-1:0] req_vec,
  input  port_id_t          ptr,
  output logic              valid,
  output port_id_t          idx
);
  port_id_t c;

  // Walk from the lowest priority (ptr itself) up to ptr+1 so the last hit wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    c     = '0;
    for (int k = NPORTS; k >= 1; k--) begin
      c = ptr + port_id_t'(k);
      if (req_vec[c]) begin
        valid = 1'b1;
        idx   = c;
      end
    end
  end
endmodule

// File: rtl/router_arb.sv
// Crossbar output arbiter: one IDLE/OWNED FSM per output with round-robin pick and hold timeout.
module router_arb #(
  parameter int NPORTS  = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic                                clock,
  input  logic                                reset_n,
  input  logic [NPORTS-1:0]                   req,
  input  logic [NPORTS*router_pkg::PORT_W-1:0] req_da,
  input  logic [NPORTS-1:0]                   rel,
  output logic [NPORTS-1:0]                   grant,
  output logic [NPORTS-1:0]                   busy_n,
  output logic [NPORTS-1:0]                   oe,
  output logic [NPORTS*router_pkg::PORT_W-1:0] sel,
  output logic [NPORTS-1:0]                   err
);
  import router_pkg::*;

  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  port_id_t [NPORTS-1:0]             da;
  logic [NPORTS-1:0][NPORTS-1:0]     gnt_oh;
  logic [NPORTS-1:0]                 grant_nxt;

  assign da = req_da;

  for (genvar o = 0; o < NPORTS; o++) begin : g_out
    arb_state_t        state_q, state_d;
    port_id_t          sel_q, sel_d, ptr_q, ptr_d, win;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d, win_vld;
    logic [NPORTS-1:0] cand;

    always_comb begin
      cand = '0;
      for (int i = 0; i < NPORTS; i++)
        cand[i] = req[i] && (da[i] == port_id_t'(o)) && !grant[i];
    end

    router_rr_pick u_pick (
      .req_vec (cand),
      .ptr     (ptr_q),
      .valid   (win_vld),
      .idx     (win)
    );

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        state_q <= IDLE;
        sel_q   <= '0;
        ptr_q   <= '1;
        cnt_q   <= '0;
        err_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        sel_q   <= sel_d;
        ptr_q   <= ptr_d;
        cnt_q   <= cnt_d;
        err_q   <= err_d;
      end
    end

    // A release in the timeout cycle takes precedence, so err stays clear.
    always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      case (state_q)
        IDLE: begin
          if (win_vld) begin
            state_d = OWNED;
            sel_d   = win;
            cnt_d   = '0;
          end
        end
        OWNED: begin
          cnt_d = cnt_q + 1'b1;
          if (rel[sel_q]) begin
            state_d = IDLE;
            sel_d   = '0;
            ptr_d   = sel_q;
            cnt_d   = '0;
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            state_d = IDLE;
            sel_d   = '0;
            ptr_d   = sel_q;
            cnt_d   = '0;
            err_d   = 1'b1;
          end
        end
      endcase
    end

    assign gnt_oh[o] = (state_d == OWNED) ? (NPORTS'(1) << sel_d) : '0;
    assign oe[o]     = (state_q == OWNED);
    assign err[o]    = err_q;
    assign sel[o*PORT_W +: PORT_W] = sel_q;
  end

  // Each input targets a single output, so OR-ing the one-hots never collides.
  always_comb begin
    grant_nxt = '0;
    for (int o = 0; o < NPORTS; o++)
      grant_nxt = grant_nxt | gnt_oh[o];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      grant  <= '0;
      busy_n <= '1;
    end else begin
      grant  <= grant_nxt;
      busy_n <= ~(req & ~grant_nxt);
    end
  end
endmodule

// File: tb/tb_router_arb.sv
// Directed bench for router_arb with an expected-output queue checked after each edge.
module tb_router_arb;
  import router_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [15:0] req, rel, grant, busy_n, oe, err;
  logic [63:0] req_da, sel;
  int          checks = 0;
  int          failures = 0;

  typedef struct {
    string       tag;
    logic [15:0] g, o, b, e;
    logic [63:0] s;
  } exp_t;
  exp_t sb[$];

  router_arb dut (
    .clock   (clock),
    .reset_n (reset_n),
    .req     (req),
    .req_da  (req_da),
    .rel     (rel),
    .grant   (grant),
    .busy_n  (busy_n),
    .oe      (oe),
    .sel     (sel),
    .err     (err)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic push(string tag, logic [15:0] g, logic [15:0] o, logic [15:0] b,
                      logic [15:0] e, logic [63:0] s);
    exp_t x;
    x.tag = tag; x.g = g; x.o = o; x.b = b; x.e = e; x.s = s;
    sb.push_back(x);
  endtask

  task automatic drain();
    exp_t x;
    while (sb.size() > 0) begin
      x = sb.pop_front();
      chk({x.tag, ".grant"},  64'(grant),  64'(x.g));
      chk({x.tag, ".oe"},     64'(oe),     64'(x.o));
      chk({x.tag, ".busy_n"}, 64'(busy_n), 64'(x.b));
      chk({x.tag, ".err"},    64'(err),    64'(x.e));
      chk({x.tag, ".sel"},    sel,         x.s);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    drain();
  endtask

  function automatic logic [63:0] put(logic [63:0] v, int o, int i);
    logic [63:0] r;
    r = v;
    r[o*4 +: 4] = 4'(i);
    return r;
  endfunction

  task automatic set_da(int i, int d);
    req_da[i*4 +: 4] = 4'(d);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req = '0; rel = '0; req_da = '0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    logic [63:0] s;
    int n;
    reset_n = 1'b1; req = '0; rel = '0; req_da = '0;
    #2 reset_n = 1'b0;
    #1;
    push("reset", 16'h0, 16'h0, 16'hFFFF, 16'h0, 64'h0);
    drain();
    @(posedge clock); #1;
    reset_n = 1'b1;

    // single request, input 3 -> output 7
    req[3] = 1'b1; set_da(3, 7);
    push("t1_grant", 16'h0008, 16'h0080, 16'hFFFF, 16'h0, put(64'h0, 7, 3)); step();
    repeat (4) begin
      push("t1_hold", 16'h0008, 16'h0080, 16'hFFFF, 16'h0, put(64'h0, 7, 3)); step();
    end
    rel[3] = 1'b1; req[3] = 1'b0;
    push("t1_rel", 16'h0, 16'h0, 16'hFFFF, 16'h0, 64'h0); step();
    rel = '0;
    push("t1_idle", 16'h0, 16'h0, 16'hFFFF, 16'h0, 64'h0); step();

    // contention: 2, 5, 9 -> output 0
    do_reset();
    req = 16'h0224;
    push("t2_g2", 16'h0004, 16'h0001, 16'hFDDF, 16'h0, put(64'h0, 0, 2)); step();
    push("t2_h2", 16'h0004, 16'h0001, 16'hFDDF, 16'h0, put(64'h0, 0, 2)); step();
    rel = 16'h0004; req = 16'h0220;
    push("t2_rel2", 16'h0, 16'h0, 16'hFDDF, 16'h0, 64'h0); step();
    rel = '0;
    push("t2_g5", 16'h0020, 16'h0001, 16'hFDFF, 16'h0, put(64'h0, 0, 5)); step();
    rel = 16'h0020; req = 16'h0200;
    push("t2_rel5", 16'h0, 16'h0, 16'hFDFF, 16'h0, 64'h0); step();
    rel = '0;
    push("t2_g9", 16'h0200, 16'h0001, 16'hFFFF, 16'h0, put(64'h0, 0, 9)); step();
    rel = 16'h0200; req = '0;
    push("t2_rel9", 16'h0, 16'h0, 16'hFFFF, 16'h0, 64'h0); step();
    rel = '0;

    // fairness on output 4: input 0 re-requests, input 1 must win next
    set_da(0, 4); set_da(1, 4); req = 16'h0003;
    push("t3_g0", 16'h0001, 16'h0010, 16'hFFFD, 16'h0, put(64'h0, 4, 0)); step();
    rel = 16'h0001;
    push("t3_rel0", 16'h0, 16'h0, 16'hFFFC, 16'h0, 64'h0); step();
    rel = '0;
    push("t3_g1", 16'h0002, 16'h0010, 16'hFFFE, 16'h0, put(64'h0, 4, 1)); step();
    rel = 16'h0002; req = 16'h0001;
    push("t3_rel1", 16'h0, 16'h0, 16'hFFFE, 16'h0, 64'h0); step();
    rel = '0;
    push("t3_g0b", 16'h0001, 16'h0010, 16'hFFFF, 16'h0, put(64'h0, 4, 0)); step();
    rel = 16'h0001; req = '0;
    push("t3_rel0b", 16'h0, 16'h0, 16'hFFFF, 16'h0, 64'h0); step();
    rel = '0;

    // 16 parallel grants, then withdraw and retarget on output 12
    do_reset();
    s = '0;
    for (int i = 0; i < 16; i++) begin
      set_da(i, 15 - i);
      s = put(s, 15 - i, i);
    end
    req = 16'hFFFF;
    push("t4_par", 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0, s); step();
    rel = 16'hFFFF; req = '0;
    push("t4_rel", 16'h0, 16'h0, 16'hFFFF, 16'h0, 64'h0); step();
    rel = '0;
    set_da(6, 12); set_da(10, 12); req = 16'h0440;
    push("t4_g6", 16'h0040, 16'h1000, 16'hFBFF, 16'h0, put(64'h0, 12, 6)); step();
    req = 16'h0040;
    push("t4_wd", 16'h0040, 16'h1000, 16'hFFFF, 16'h0, put(64'h0, 12, 6)); step();
    rel = 16'h0040; req = '0;
    push("t4_rel6", 16'h0, 16'h0, 16'hFFFF, 16'h0, 64'h0); step();
    rel = '0;
    repeat (2) begin
      push("t4_nogrant", 16'h0, 16'h0, 16'hFFFF, 16'h0, 64'h0); step();
    end
    req = 16'h0440;
    push("t4_g10", 16'h0400, 16'h1000, 16'hFFBF, 16'h0, put(64'h0, 12, 10)); step();
    set_da(6, 13);
    push("t4_retgt", 16'h0440, 16'h3000, 16'hFFFF, 16'h0, put(put(64'h0, 12, 10), 13, 6)); step();
    rel = 16'h0440; req = '0;
    push("t4_relall", 16'h0, 16'h0, 16'hFFFF, 16'h0, 64'h0); step();
    rel = '0;

    // timeout on output 2 held by input 8
    do_reset();
    set_da(8, 2); req = 16'h0100;
    push("t5_grant", 16'h0100, 16'h0004, 16'hFFFF, 16'h0, put(64'h0, 2, 8)); step();
    n = 1;
    while (oe[2] && n < 2000) begin
      @(posedge clock); #1;
      if (oe[2]) n++;
    end
    req = '0;
    chk("t5_hold_len", 64'(n), 64'(1024));
    chk("t5_err", 64'(err), 64'(16'h0004));
    chk("t5_grant_clr", 64'(grant), 64'h0);
    chk("t5_sel_clr", sel, 64'h0);
    repeat (3) begin
      push("t5_sticky", 16'h0, 16'h0, 16'hFFFF, 16'h0004, 64'h0); step();
    end

    // release in the timeout cycle wins, no err
    do_reset();
    chk("t5b_err_reset", 64'(err), 64'h0);
    set_da(8, 2); req = 16'h0100;
    push("t5b_grant", 16'h0100, 16'h0004, 16'hFFFF, 16'h0, put(64'h0, 2, 8)); step();
    repeat (1023) begin
      @(posedge clock); #1;
    end
    chk("t5b_still_owned", 64'(oe), 64'(16'h0004));
    rel = 16'h0100; req = '0;
    push("t5b_rel", 16'h0, 16'h0, 16'hFFFF, 16'h0, 64'h0); step();
    rel = '0;
    push("t5b_idle", 16'h0, 16'h0, 16'hFFFF, 16'h0, 64'h0); step();

    // reset while 8 outputs are owned
    do_reset();
    s = '0;
    for (int i = 0; i < 8; i++) begin
      set_da(i, i + 8);
      s = put(s, i + 8, i);
    end
    set_da(9, 8);
    req = 16'h02FF;
    push("t6_owned", 16'h00FF, 16'hFF00, 16'hFDFF, 16'h0, s); step();
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    push("t6_async_rst", 16'h0, 16'h0, 16'hFFFF, 16'h0, 64'h0);
    drain();
    #1 reset_n = 1'b1;
    push("t6_rearb", 16'h00FF, 16'hFF00, 16'hFDFF, 16'h0, s); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/router_arb.md
ROUTER_ARB -- requirements
Module: router_arb

Interface
REQ-001 Parameters SHALL be: NPORTS, 16, number of input and output ports; TIMEOUT, 1024, maximum cycles one owner may hold an output.
REQ-002 clock  input  1  single rising-edge clock for all state.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 req  input  16  per-input level request; held from packet start until the release cycle.
REQ-005 req_da  input  64  per-input 4-bit destination port; input i uses bits [4i+3:4i]; sampled while req[i] is high.
REQ-006 rel  input  16  per-input one-cycle release pulse at end of packet (last frame bit).
REQ-007 grant  output  16  per-input grant; high while the input owns its destination output.
REQ-008 busy_n  output  16  per-input, active-low; low while req[i] is high and grant[i] is low.
REQ-009 oe  output  16  per-output enable; high while the output is owned.
REQ-010 sel  output  64  per-output 4-bit owning-input index; output o uses bits [4o+3:4o]; 0 when not owned.
REQ-011 err  output  16  per-output sticky timeout flag.

Function
REQ-012 Each output SHALL run an independent FSM with states IDLE and OWNED.
REQ-013 IDLE: the candidate set for output o SHALL be all inputs with req[i]=1, req_da[i]=o and grant[i]=0.
REQ-014 IDLE with a non-empty candidate set: the FSM SHALL pick by round-robin, searching from ptr[o]+1 upward modulo 16.
- It SHALL move to OWNED on the next edge, with oe[o]=1, sel[o]=winner and grant[winner]=1 (latency: 1 cycle from req to grant).
REQ-015 OWNED: when rel[sel[o]]=1, the FSM SHALL go to IDLE on the next edge.
- oe[o], grant[owner] and sel[o] SHALL clear on that edge, and ptr[o] SHALL be set to the owner.
REQ-016 A released output SHALL spend at least one cycle in IDLE; the next grant is therefore no earlier than 2 cycles after rel.
REQ-017 rel from a non-owning input SHALL be ignored.
- req deasserted before grant SHALL withdraw the request with no grant.
- A change of req_da before grant SHALL retarget the request.
REQ-018 While OWNED, a per-output hold counter SHALL increment every cycle.
- Reaching TIMEOUT-1 without rel SHALL force the IDLE transition as in REQ-015 and set err[o].
- Counter width SHALL be clog2(TIMEOUT)+1.
- The counter SHALL clear on entry to OWNED.
REQ-019 rel and timeout in the same cycle SHALL be treated as rel; err is not set.
REQ-020 err[o] SHALL remain set until reset.
REQ-021 Since each input has one destination, grant bits from different outputs SHALL never target the same input; grant SHALL be the OR of per-output one-hot grants.
REQ-022 busy_n SHALL be registered, updating on the same edge as grant.
REQ-023 All outputs SHALL be registered, with no combinational input-to-output paths.

Reset
REQ-024 reset_n low SHALL asynchronously force:
- all FSMs to IDLE;
- grant=0, oe=0, sel=0, err=0, busy_n=all ones;
- hold counters=0;
- ptr[o]=15, so input 0 has first priority.
REQ-025 Reset during OWNED SHALL drop ownership immediately, with no err.
- Requests still held after reset release SHALL be re-arbitrated from the reset priority.

Structure
REQ-026 A shared package router_pkg SHALL hold the constants NPORTS and PORT_W=4, typedef port_id_t (logic [3:0]) and enum arb_state_t {IDLE, OWNED}.
REQ-027 A sub-module router_rr_pick SHALL implement one combinational 16-way round-robin picker (request vector, pointer in; valid and index out).
- router_arb SHALL instantiate it once per output.

Verification
REQ-028 Single request: req[3]=1 with da=7 at cycle 0 -> grant[3], oe[7]=1 and sel[7]=3 at cycle 1; rel[3] at cycle 5 -> all cleared at cycle 6.
REQ-029 Contention: inputs 2, 5 and 9 all target output 0 after reset -> granted in order 2, 5, 9, each grant at least 2 cycles after the previous rel; busy_n low for the waiters.
REQ-030 Fairness: input 0 re-requests output 4 immediately after release while input 1 waits -> input 1 is granted next.
REQ-031 Timeout: owner holds output 2 with no rel -> forced release at hold count TIMEOUT-1, err[2]=1 and sticky; rel in the same cycle -> err[2] stays 0.
REQ-032 Parallel and withdraw: 16 inputs target 16 distinct outputs -> all granted in cycle 1; an input that drops req before grant is never granted.
REQ-033 Reset while 8 outputs are owned -> all outputs return to reset values with no clock edge; re-arbitration starts from input 0.
